// File: rtl/gmii_tx_framer.sv
// GMII transmit framer: preamble/SFD, payload, zero pad, CRC-32 FCS, then enforced inter-packet gap.
// States: IDLE wait | PRE preamble+SFD | DATA payload | PAD zero fill | FCS crc out | DRAIN discard | IPG gap.
module gmii_tx_framer #(
  parameter int IPG_MIN   = 12,
  parameter int MIN_FRAME = 60,
  parameter int MAX_FRAME = 1514
) (
  input  logic       gmii_tx_clk,
  input  logic       rst,
  input  logic [7:0] s_data,
  input  logic       s_valid,
  input  logic       s_last,
  output logic       s_ready,
  output logic [7:0] gmii_data_out,
  output logic       gmii_en_out,
  output logic       tx_busy,
  output logic       frame_done,
  output logic       tx_underrun,
  output logic       tx_oversize
);
  localparam int            IW       = $clog2(IPG_MIN + 2);
  localparam logic [IW-1:0] IPG_L    = IW'(IPG_MIN);
  localparam logic [10:0]   MIN_L    = 11'(MIN_FRAME);
  localparam logic [10:0]   MAX_L    = 11'(MAX_FRAME);
  localparam logic [31:0]   CRC_INIT = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {
    S_IDLE, S_PRE, S_DATA, S_PAD, S_FCS, S_DRAIN, S_IPG
  } state_t;

  state_t        state_q, state_d;
  logic [2:0]    pre_cnt_q, pre_cnt_d;
  logic [10:0]   count_q, count_d;
  logic [31:0]   crc_q, crc_d;
  logic [1:0]    fcs_cnt_q, fcs_cnt_d;
  logic [IW-1:0] ipg_cnt_q, ipg_cnt_d;
  logic          bad_q, bad_d;
  logic          ovs_q, ovs_d;
  logic [7:0]    data_q, data_d;
  logic          en_q, en_d;
  logic          done_q, done_d;
  logic          und_q, und_d;
  logic          ovsp_q, ovsp_d;

  logic [10:0]   count_inc;
  logic [IW-1:0] ipg_inc;
  logic          start;
  logic          hit_max;

  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c ^ {24'h0, b};
    for (int i = 0; i < 8; i++) r = r[0] ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
    return r;
  endfunction

  // A bad frame sends the raw register, i.e. the complement of the correct FCS.
  function automatic logic [7:0] fcs_byte(input logic [31:0] c, input logic [1:0] idx, input logic bad);
    logic [7:0] b;
    case (idx)
      2'd0:    b = c[7:0];
      2'd1:    b = c[15:8];
      2'd2:    b = c[23:16];
      default: b = c[31:24];
    endcase
    return bad ? b : ~b;
  endfunction

  assign count_inc = count_q + 11'd1;
  assign ipg_inc   = (ipg_cnt_q == IPG_L) ? ipg_cnt_q : ipg_cnt_q + IW'(1);
  assign start     = s_valid && (ipg_cnt_q == IPG_L);
  assign hit_max   = !s_last && (count_inc == MAX_L);
  assign s_ready   = (state_q == S_DATA) || (state_q == S_DRAIN);
  assign tx_busy   = (state_q != S_IDLE);

  always_ff @(posedge gmii_tx_clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      pre_cnt_q <= '0;
      count_q   <= '0;
      crc_q     <= CRC_INIT;
      fcs_cnt_q <= '0;
      ipg_cnt_q <= IPG_L;
      bad_q     <= 1'b0;
      ovs_q     <= 1'b0;
      data_q    <= 8'h00;
      en_q      <= 1'b0;
      done_q    <= 1'b0;
      und_q     <= 1'b0;
      ovsp_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pre_cnt_q <= pre_cnt_d;
      count_q   <= count_d;
      crc_q     <= crc_d;
      fcs_cnt_q <= fcs_cnt_d;
      ipg_cnt_q <= ipg_cnt_d;
      bad_q     <= bad_d;
      ovs_q     <= ovs_d;
      data_q    <= data_d;
      en_q      <= en_d;
      done_q    <= done_d;
      und_q     <= und_d;
      ovsp_q    <= ovsp_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pre_cnt_d = pre_cnt_q;
    count_d   = count_q;
    crc_d     = crc_q;
    fcs_cnt_d = fcs_cnt_q;
    ipg_cnt_d = ipg_cnt_q;
    bad_d     = bad_q;
    ovs_d     = ovs_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_PRE;
          pre_cnt_d = '0;
        end
      end
      S_PRE: begin
        crc_d     = CRC_INIT;
        count_d   = '0;
        fcs_cnt_d = '0;
        bad_d     = 1'b0;
        ovs_d     = 1'b0;
        pre_cnt_d = pre_cnt_q + 3'd1;
        if (pre_cnt_q == 3'd6) state_d = S_DATA;
      end
      S_DATA: begin
        if (!s_valid) begin
          // FCS byte 0 leaves in this cycle so the frame has no bubble.
          bad_d     = 1'b1;
          fcs_cnt_d = 2'd1;
          state_d   = S_FCS;
        end else begin
          crc_d   = crc_byte(crc_q, s_data);
          count_d = count_inc;
          if (s_last) begin
            state_d = (count_inc < MIN_L) ? S_PAD : S_FCS;
          end else if (hit_max) begin
            bad_d   = 1'b1;
            ovs_d   = 1'b1;
            state_d = S_FCS;
          end
        end
      end
      S_PAD: begin
        crc_d   = crc_byte(crc_q, 8'h00);
        count_d = count_inc;
        if (count_inc >= MIN_L) state_d = S_FCS;
      end
      S_FCS: begin
        fcs_cnt_d = fcs_cnt_q + 2'd1;
        if (fcs_cnt_q == 2'd3) begin
          ipg_cnt_d = '0;
          state_d   = ovs_q ? S_DRAIN : S_IPG;
        end
      end
      S_DRAIN: begin
        ipg_cnt_d = ipg_inc;
        if (s_valid && s_last) state_d = S_IPG;
      end
      S_IPG: begin
        ipg_cnt_d = ipg_inc;
        if (ipg_inc == IPG_L) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    data_d = 8'h00;
    en_d   = 1'b0;
    done_d = 1'b0;
    und_d  = 1'b0;
    ovsp_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          data_d = 8'h55;
          en_d   = 1'b1;
        end
      end
      S_PRE: begin
        en_d   = 1'b1;
        data_d = (pre_cnt_q == 3'd6) ? 8'hD5 : 8'h55;
      end
      S_DATA: begin
        en_d = 1'b1;
        if (!s_valid) begin
          data_d = fcs_byte(crc_q, 2'd0, 1'b1);
          und_d  = 1'b1;
        end else begin
          data_d = s_data;
          ovsp_d = hit_max;
        end
      end
      S_PAD: en_d = 1'b1;
      S_FCS: begin
        en_d   = 1'b1;
        data_d = fcs_byte(crc_q, fcs_cnt_q, bad_q);
        done_d = (fcs_cnt_q == 2'd3);
      end
      default: ;
    endcase
  end

  assign gmii_data_out = data_q;
  assign gmii_en_out   = en_q;
  assign frame_done    = done_q;
  assign tx_underrun   = und_q;
  assign tx_oversize   = ovsp_q;

endmodule

// File: tb/tb_gmii_tx_framer.sv
// Directed bench for gmii_tx_framer: three instances (MIN_FRAME=0, defaults, MAX_FRAME=100)
// driven one at a time; a monitor captures each GMII frame for comparison with a reference CRC model.
module tb_gmii_tx_framer;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0]      rst;
  logic [2:0]      s_valid;
  logic [2:0]      s_last;
  logic [2:0][7:0] s_data;
  wire  [2:0]      s_ready_o;
  wire  [2:0][7:0] data_o;
  wire  [2:0]      en_o, busy_o, done_o, und_o, ovs_o;

  gmii_tx_framer #(.MIN_FRAME(0)) u_min0 (
    .gmii_tx_clk(clk), .rst(rst[0]), .s_data(s_data[0]), .s_valid(s_valid[0]), .s_last(s_last[0]),
    .s_ready(s_ready_o[0]), .gmii_data_out(data_o[0]), .gmii_en_out(en_o[0]), .tx_busy(busy_o[0]),
    .frame_done(done_o[0]), .tx_underrun(und_o[0]), .tx_oversize(ovs_o[0]));

  gmii_tx_framer u_dflt (
    .gmii_tx_clk(clk), .rst(rst[1]), .s_data(s_data[1]), .s_valid(s_valid[1]), .s_last(s_last[1]),
    .s_ready(s_ready_o[1]), .gmii_data_out(data_o[1]), .gmii_en_out(en_o[1]), .tx_busy(busy_o[1]),
    .frame_done(done_o[1]), .tx_underrun(und_o[1]), .tx_oversize(ovs_o[1]));

  gmii_tx_framer #(.MAX_FRAME(100)) u_max100 (
    .gmii_tx_clk(clk), .rst(rst[2]), .s_data(s_data[2]), .s_valid(s_valid[2]), .s_last(s_last[2]),
    .s_ready(s_ready_o[2]), .gmii_data_out(data_o[2]), .gmii_en_out(en_o[2]), .tx_busy(busy_o[2]),
    .frame_done(done_o[2]), .tx_underrun(und_o[2]), .tx_oversize(ovs_o[2]));

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int sel = 1;
  int v_cyc = -1;

  logic [7:0] rx_all[$];
  int         flen[$];
  int         gaps[$];
  int         done_idx[$];
  int         cur_len = 0, gap_cnt = 0, und_cnt = 0, ovs_cnt = 0, first_en_cyc = -1;
  logic       prev_en = 1'b0;

  logic [8:0] st[$];
  logic [7:0] pl[$];
  logic [7:0] xq[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    if (en_o[sel]) begin
      rx_all.push_back(data_o[sel]);
      cur_len++;
      if (!prev_en && flen.size() > 0) gaps.push_back(gap_cnt);
      if (!prev_en && first_en_cyc < 0) first_en_cyc = cyc;
    end else begin
      if (prev_en) begin
        flen.push_back(cur_len);
        cur_len = 0;
        gap_cnt = 0;
      end
      gap_cnt++;
    end
    if (done_o[sel]) done_idx.push_back(rx_all.size());
    if (und_o[sel]) und_cnt++;
    if (ovs_o[sel]) ovs_cnt++;
    prev_en = en_o[sel];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", tag, got, want);
    end
  endtask

  task automatic clear_cap();
    rx_all.delete(); flen.delete(); gaps.delete(); done_idx.delete();
    cur_len = 0; gap_cnt = 0; und_cnt = 0; ovs_cnt = 0; first_en_cyc = -1;
  endtask

  function automatic logic [31:0] crc_ref(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c;
    for (int k = 0; k < 8; k++) begin
      if (r[0] ^ b[k]) r = (r >> 1) ^ 32'hEDB8_8320;
      else             r = r >> 1;
    end
    return r;
  endfunction

  // Expected GMII frame for payload pl: preamble, payload, pad to minf, FCS (raw register if bad).
  task automatic mk_exp(input int minf, input bit bad);
    logic [31:0] c;
    logic [7:0]  b;
    int          n;
    xq.delete();
    for (int k = 0; k < 7; k++) xq.push_back(8'h55);
    xq.push_back(8'hD5);
    c = 32'hFFFF_FFFF;
    n = 0;
    foreach (pl[k]) begin
      xq.push_back(pl[k]);
      c = crc_ref(c, pl[k]);
      n++;
    end
    while (n < minf) begin
      xq.push_back(8'h00);
      c = crc_ref(c, 8'h00);
      n++;
    end
    for (int k = 0; k < 4; k++) begin
      b = c[8*k +: 8];
      xq.push_back(bad ? b : ~b);
    end
  endtask

  task automatic chk_frame(input string tag, input int k);
    int off = 0;
    logic [31:0] got;
    if (flen.size() <= k) begin
      chk({tag, "_present"}, flen.size(), k + 1);
      return;
    end
    for (int j = 0; j < k; j++) off += flen[j];
    chk({tag, "_len"}, flen[k], xq.size());
    for (int j = 0; j < xq.size(); j++) begin
      got = (off + j < rx_all.size()) ? {24'h0, rx_all[off+j]} : 32'h100;
      chk($sformatf("%s_b%0d", tag, j), got, {24'h0, xq[j]});
    end
    chk({tag, "_done"}, (done_idx.size() > k) ? done_idx[k] : 0, off + flen[k]);
  endtask

  task automatic run_stream(input int d, input int drop_at, input int rst_at, output int acc);
    int i = 0;
    int n = 0;
    logic [8:0] e;
    while (i < st.size()) begin
      @(negedge clk);
      n++;
      if (n > 5000) begin
        chk("stream_budget", i, st.size());
        break;
      end
      if (i == drop_at) begin
        s_valid[d] = 1'b0; s_last[d] = 1'b0;
        break;
      end
      if (i == rst_at) begin
        rst[d] = 1'b1; s_valid[d] = 1'b0; s_last[d] = 1'b0;
        break;
      end
      e = st[i];
      s_valid[d] = 1'b1;
      s_data[d]  = e[7:0];
      s_last[d]  = e[8];
      if (v_cyc < 0) v_cyc = cyc;
      if (s_ready_o[d]) i++;
    end
    if (i == st.size()) begin
      @(negedge clk);
      s_valid[d] = 1'b0; s_last[d] = 1'b0;
    end
    acc = i;
  endtask

  task automatic wait_idle(input int d);
    int n = 0;
    while (busy_o[d] && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("idle_timeout", busy_o[d], 1'b0);
    repeat (3) @(negedge clk);
  endtask

  task automatic add_frame(input int len, input int seed);
    for (int k = 0; k < len; k++) st.push_back({(k == len - 1), 8'((k * 7 + seed) & 8'hFF)});
  endtask

  task automatic pl_from_st(input int from, input int len);
    logic [8:0] e;
    pl.delete();
    for (int k = 0; k < len; k++) begin
      e = st[from + k];
      pl.push_back(e[7:0]);
    end
  endtask

  int acc;

  initial begin
    rst = '1; s_valid = '0; s_last = '0; s_data = '0;
    repeat (3) @(negedge clk);
    chk("rst_data",  data_o[1],    8'h00);
    chk("rst_en",    en_o[1],      1'b0);
    chk("rst_ready", s_ready_o[1], 1'b0);
    chk("rst_busy",  busy_o[1],    1'b0);
    chk("rst_done",  done_o[1],    1'b0);
    chk("rst_und",   und_o[1],     1'b0);
    chk("rst_ovs",   ovs_o[1],     1'b0);
    rst = '0;
    repeat (2) @(negedge clk);

    // "123456789" with no padding: known CRC 0xCBF43926
    sel = 0; clear_cap(); v_cyc = -1;
    st.delete();
    for (int k = 0; k < 9; k++) st.push_back({(k == 8), 8'(8'h31 + k)});
    run_stream(0, -1, -1, acc);
    wait_idle(0);
    xq.delete();
    for (int k = 0; k < 7; k++) xq.push_back(8'h55);
    xq.push_back(8'hD5);
    for (int k = 0; k < 9; k++) xq.push_back(8'(8'h31 + k));
    xq.push_back(8'h26); xq.push_back(8'h39); xq.push_back(8'hF4); xq.push_back(8'hCB);
    chk_frame("chk9", 0);
    chk("chk9_latency", first_en_cyc - v_cyc, 1);
    chk("chk9_und", und_cnt, 0);

    // 14-byte payload padded to 60
    sel = 1; clear_cap();
    st.delete(); add_frame(14, 3);
    run_stream(1, -1, -1, acc);
    wait_idle(1);
    pl_from_st(0, 14); mk_exp(60, 1'b0);
    chk_frame("pad14", 0);

    // two back-to-back 64-byte frames with s_valid held
    clear_cap();
    st.delete(); add_frame(64, 1); add_frame(64, 90);
    run_stream(1, -1, -1, acc);
    wait_idle(1);
    pl_from_st(0, 64);  mk_exp(60, 1'b0); chk_frame("b2b_a", 0);
    pl_from_st(64, 64); mk_exp(60, 1'b0); chk_frame("b2b_b", 1);
    chk("b2b_gap", (gaps.size() > 0) ? gaps[0] : 0, 12);

    // underrun after 20 bytes
    clear_cap();
    st.delete(); add_frame(40, 11);
    run_stream(1, 20, -1, acc);
    wait_idle(1);
    pl_from_st(0, 20); mk_exp(0, 1'b1);
    chk_frame("undr", 0);
    chk("undr_pulses", und_cnt, 1);
    chk("undr_ovs", ovs_cnt, 0);

    // oversize on the MAX_FRAME=100 instance, then a normal frame
    sel = 2; clear_cap();
    st.delete(); add_frame(150, 5); add_frame(10, 200);
    run_stream(2, -1, -1, acc);
    wait_idle(2);
    chk("ovs_accepted", acc, 160);
    pl_from_st(0, 100); mk_exp(60, 1'b1); chk_frame("ovs", 0);
    pl_from_st(150, 10); mk_exp(60, 1'b0); chk_frame("ovs_next", 1);
    chk("ovs_pulses", ovs_cnt, 1);
    chk("ovs_gap_ge12", (gaps.size() > 0) ? (gaps[0] >= 12) : 0, 1);

    // reset mid-DATA, then a clean frame
    sel = 1; clear_cap();
    st.delete(); add_frame(30, 17);
    run_stream(1, -1, 10, acc);
    @(negedge clk);
    rst[1] = 1'b0;
    chk("mid_rst_en",    en_o[1],      1'b0);
    chk("mid_rst_ready", s_ready_o[1], 1'b0);
    chk("mid_rst_busy",  busy_o[1],    1'b0);
    chk("mid_rst_data",  data_o[1],    8'h00);
    @(negedge clk);
    chk("mid_rst_nodone", done_idx.size(), 0);
    chk("mid_rst_nound",  und_cnt, 0);
    clear_cap();
    st.delete(); add_frame(64, 33);
    run_stream(1, -1, -1, acc);
    wait_idle(1);
    pl_from_st(0, 64); mk_exp(60, 1'b0);
    chk_frame("after_rst", 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/gmii_tx_framer.md
# gmii_tx_framer

Transmit-side Ethernet framer on the GMII TX clock domain. Takes a raw payload byte stream (destination MAC through end of payload, no preamble/FCS) over a valid/ready/last handshake and drives a complete GMII frame: preamble, SFD, payload, zero padding to minimum length, CRC-32 FCS, then an enforced inter-packet gap. It produces frames that an IPG/length/CRC-checking receive path accepts. Malformed input (underrun, oversize) produces a frame with a deliberately corrupted FCS so that downstream receivers drop it.

## Interface
Parameters:
- IPG_MIN, 12, minimum idle cycles (gmii_en_out low) between frames.
- MIN_FRAME, 60, minimum payload+pad bytes before FCS; shorter payloads are zero-padded.
- MAX_FRAME, 1514, maximum payload bytes accepted into one frame; must be ≤ 2047.

Ports:
- gmii_tx_clk  in  1  sole clock; all logic on its rising edge.
- rst  in  1  reset, synchronous, active-high.
- s_data  in  8  payload byte.
- s_valid  in  1  s_data valid.
- s_last  in  1  s_data is the final payload byte.
- s_ready  out  1  framer accepts s_data this cycle.
- gmii_data_out  out  8  GMII TXD, registered.
- gmii_en_out  out  1  GMII TX_EN, registered.
- tx_busy  out  1  high from frame start until IPG complete.
- frame_done  out  1  one-cycle pulse, cycle of the last FCS byte.
- tx_underrun  out  1  one-cycle pulse when an underrun is detected.
- tx_oversize  out  1  one-cycle pulse when byte count reaches MAX_FRAME without s_last.

## Operation
- States: IDLE, PRE, DATA, PAD, FCS, DRAIN, IPG.
- IDLE: s_ready=0. On s_valid=1 with IPG satisfied → PRE.
- PRE: 8 output cycles, 0x55 ×7 then 0xD5. s_ready=1 in the SFD cycle.
- DATA: s_ready=1. Each handshake (s_valid&s_ready) stores the byte, feeds the CRC and increments the 11-bit byte count. Handshake with s_last → PAD if count < MIN_FRAME, else FCS.
- Underrun: s_valid=0 in any DATA cycle (including the SFD cycle) → pulse tx_underrun; go to FCS with the bad-FCS flag set; no padding.
- Oversize: count reaches MAX_FRAME with no s_last → pulse tx_oversize; go to FCS with bad FCS. Then DRAIN.
- PAD: emit 0x00, also fed to the CRC, until count = MIN_FRAME → FCS.
- FCS: 4 bytes, LSB byte first, each the complement of the CRC register. When the bad-FCS flag is set, each byte is complemented again, giving the raw register. frame_done pulses on the 4th byte. Next state is IPG, or DRAIN after an oversize.
- CRC-32: IEEE poly 0x04C11DB7, reflected, init 0xFFFFFFFF, byte-parallel, LSB-first. Reset to init in PRE.
- DRAIN: gmii_en_out=0; s_ready=1; discard bytes until a handshake with s_last → IPG. IPG counting also runs during DRAIN.
- IPG: gmii_en_out=0, s_ready=0; count IPG_MIN cycles → IDLE. A frame may start in the IDLE cycle right after.
- tx_busy=1 in every state except IDLE.
- Reset values: gmii_data_out=0x00, gmii_en_out=0, s_ready=0, tx_busy=0, frame_done=0, tx_underrun=0, tx_oversize=0. State=IDLE, IPG treated as satisfied.

## Timing
- Frame start: s_valid seen in IDLE at cycle t → first 0x55 on the GMII outputs at t+1. SFD at t+8.
- Data latency: a byte accepted at cycle c appears on gmii_data_out at c+1. Payload follows the SFD with no bubble.
- Frame length: gmii_en_out is high for exactly 8 + max(N, MIN_FRAME) + 4 contiguous cycles for a well-formed N-byte payload.
- Gap: gmii_en_out is low for at least IPG_MIN cycles between frames; exactly IPG_MIN when s_valid is held high.
- rst mid-frame: the next cycle shows reset values and state IDLE. No FCS is emitted and no status pulses occur.
- s_data and s_last are sampled only on a handshake.
- Simultaneous s_last with count reaching MAX_FRAME: treat as a normal end of frame, with no oversize.

## Test plan
- MIN_FRAME=0, payload 31..39 (ASCII "123456789") with s_last on 0x39 → en high 21 cycles: 55×7, D5, 31..39, 26 39 F4 CB; frame_done on the CB cycle.
- Default parameters, 14-byte payload → 46 bytes of 0x00 after the payload, en high 72 cycles, FCS correct over payload+pad.
- Two back-to-back 64-byte payloads, s_valid held high → en low exactly 12 cycles between frames; second preamble starts on cycle 13 of the gap.
- Underrun: s_valid dropped after 20 bytes → tx_underrun pulse; 4 FCS bytes equal the bitwise complement of the correct FCS over those 20 bytes; no pad; en high 32 cycles.
- Oversize, MAX_FRAME=100: send a 150-byte payload → tx_oversize at byte 100; bad FCS; en high 112 cycles; the remaining 50 bytes are drained; the next frame starts after ≥12 idle cycles.
- rst asserted for 1 cycle mid-DATA → en=0 and s_ready=0 the next cycle; a new frame starting immediately after is transmitted correctly.
